// File: rtl/nibble_match_ctrl.sv
// Nibble pattern-match sequencer: programmable pattern/mask/run length, valid/ready
// scan of a nibble stream, one-cycle hit pulse and a saturating hit counter.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | parked; config writes accepted; in_ready=0, busy=0
// SCAN    | accepting beats, counting consecutive matches toward run_eff
// HIT     | one-cycle hit pulse; input stalled; returns to SCAN (or IDLE on stop)
module nibble_match_ctrl #(
  parameter int W     = 4,
  parameter int CNT_W = 8,
  parameter int RUN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [W-1:0]     cfg_pattern,
  input  logic [W-1:0]     cfg_mask,
  input  logic [RUN_W-1:0] cfg_run,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             match_last,
  output logic             hit,
  output logic [CNT_W-1:0] hit_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_HIT  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [W-1:0]     pattern;
  logic [W-1:0]     mask;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_eff;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_cnt_nxt;
  logic [RUN_W:0]   run_cnt_inc;
  logic             accept;
  logic             beat_match;
  logic             run_done;
  logic             hit_take;

  assign accept      = in_valid && (state == ST_SCAN);
  assign beat_match  = ((in_data ^ pattern) & mask) == '0;
  assign run_eff     = (run == '0) ? RUN_W'(1) : run;
  // One extra bit keeps the +1 compare safe when run_eff is at its maximum.
  assign run_cnt_inc = {1'b0, run_cnt} + {{RUN_W{1'b0}}, 1'b1};
  assign run_done    = run_cnt_inc == {1'b0, run_eff};
  assign hit_take    = (state == ST_SCAN) && !stop && accept && beat_match && run_done;

  always_comb begin
    state_nxt   = state;
    run_cnt_nxt = run_cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt   = ST_SCAN;
          run_cnt_nxt = '0;
        end
      end
      ST_SCAN: begin
        if (stop) begin
          state_nxt   = ST_IDLE;
          run_cnt_nxt = '0;
        end else if (accept) begin
          if (!beat_match) begin
            run_cnt_nxt = '0;
          end else if (run_done) begin
            state_nxt   = ST_HIT;
            run_cnt_nxt = '0;
          end else begin
            run_cnt_nxt = run_cnt_inc[RUN_W-1:0];
          end
        end
      end
      ST_HIT: begin
        run_cnt_nxt = '0;
        state_nxt   = stop ? ST_IDLE : ST_SCAN;
      end
      default: begin
        state_nxt   = ST_IDLE;
        run_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      run_cnt    <= '0;
      pattern    <= '0;
      mask       <= '0;
      run        <= RUN_W'(1);
      match_last <= 1'b0;
      hit_count  <= '0;
    end else begin
      state   <= state_nxt;
      run_cnt <= run_cnt_nxt;
      if (cfg_we && (state == ST_IDLE)) begin
        pattern <= cfg_pattern;
        mask    <= cfg_mask;
        run     <= cfg_run;
      end
      if (accept) begin
        match_last <= beat_match;
      end
      if (hit_take && (hit_count != '1)) begin
        hit_count <= hit_count + CNT_W'(1);
      end
    end
  end

  assign in_ready = (state == ST_SCAN);
  assign busy     = (state != ST_IDLE);
  assign hit      = (state == ST_HIT);

endmodule

// File: tb/tb_nibble_match_ctrl.sv
// Bench for nibble_match_ctrl: directed vector table plus randomized traffic
// checked against a behavioural model; a CNT_W=2 twin exercises saturation.
module tb_nibble_match_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_pattern = '0;
  logic [3:0] cfg_mask = '0;
  logic [3:0] cfg_run = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;

  logic       in_ready, busy, match_last, hit;
  logic [7:0] hit_count;
  logic       in_ready_s, busy_s, match_last_s, hit_s;
  logic [1:0] hit_count_s;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  nibble_match_ctrl #(.W(4), .CNT_W(8), .RUN_W(4)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_mask(cfg_mask), .cfg_run(cfg_run), .start(start), .stop(stop),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
    .match_last(match_last), .hit(hit), .hit_count(hit_count)
  );

  nibble_match_ctrl #(.W(4), .CNT_W(2), .RUN_W(4)) dut_s (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_mask(cfg_mask), .cfg_run(cfg_run), .start(start), .stop(stop),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s), .busy(busy_s),
    .match_last(match_last_s), .hit(hit_s), .hit_count(hit_count_s)
  );

  // Behavioural model: phase 0 = parked, 1 = scanning, 2 = reporting a hit.
  int         m_phase = 0;
  int         m_streak = 0;
  int         m_hits = 0;
  logic [3:0] m_pat = '0, m_msk = '0, m_run = 4'd1;
  logic       m_ml = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic tick(input string tag);
    logic acc, mt;
    int need;
    if (rst) begin
      m_phase = 0; m_streak = 0; m_hits = 0;
      m_pat = '0; m_msk = '0; m_run = 4'd1; m_ml = 1'b0;
    end else begin
      acc  = (m_phase == 1) && in_valid;
      mt   = ((in_data ^ m_pat) & m_msk) == 4'd0;
      need = (m_run == 0) ? 1 : int'(m_run);
      if (acc) m_ml = mt;
      if (m_phase == 0) begin
        if (cfg_we) begin m_pat = cfg_pattern; m_msk = cfg_mask; m_run = cfg_run; end
        if (start) begin m_phase = 1; m_streak = 0; end
      end else if (stop) begin
        m_phase = 0; m_streak = 0;
      end else if (m_phase == 2) begin
        m_phase = 1;
      end else if (acc) begin
        if (!mt) m_streak = 0;
        else if (m_streak + 1 >= need) begin m_phase = 2; m_streak = 0; m_hits++; end
        else m_streak++;
      end
    end
    @(posedge clk); #1;
    chk({tag, "/model"},
        {in_ready, busy, match_last, hit, hit_count, in_ready_s, busy_s, match_last_s, hit_s, hit_count_s},
        {m_phase == 1, m_phase != 0, m_ml, m_phase == 2, 8'((m_hits > 255) ? 255 : m_hits),
         m_phase == 1, m_phase != 0, m_ml, m_phase == 2, 2'((m_hits > 3) ? 3 : m_hits)});
  endtask

  typedef struct {
    logic r, we; logic [3:0] pat, msk, run; logic st, sp, vl; logic [3:0] d;
    logic er, eb, eml, eh; int ec, ecs;
  } vec_t;
  vec_t tbl[$];

  task automatic v(input logic r, we, input logic [3:0] pat, msk, run,
                   input logic st, sp, vl, input logic [3:0] d,
                   input logic er, eb, eml, eh, input int ec, ecs);
    vec_t x;
    x = '{r, we, pat, msk, run, st, sp, vl, d, er, eb, eml, eh, ec, ecs};
    tbl.push_back(x);
  endtask

  initial begin
    // single-beat match with don't-care
    v(0,1,4'hC,4'hE,1, 1,0,0,4'h0, 1,1,0,0, 0,0);
    v(0,0,0,0,0, 0,0,1,4'hD, 0,1,1,1, 1,1);
    v(0,0,0,0,0, 0,0,0,4'h0, 1,1,1,0, 1,1);
    v(0,0,0,0,0, 0,0,1,4'hE, 1,1,0,0, 1,1);
    v(0,0,0,0,0, 0,0,1,4'hC, 0,1,1,1, 2,2);
    v(0,0,0,0,0, 0,0,0,4'h0, 1,1,1,0, 2,2);
    v(0,0,0,0,0, 0,1,0,4'h0, 0,0,1,0, 2,2);
    // run length 3 with a break
    v(0,1,4'hC,4'hF,3, 1,0,0,4'h0, 1,1,1,0, 2,2);
    v(0,0,0,0,0, 0,0,1,4'hC, 1,1,1,0, 2,2);
    v(0,0,0,0,0, 0,0,1,4'hC, 1,1,1,0, 2,2);
    v(0,0,0,0,0, 0,0,1,4'h0, 1,1,0,0, 2,2);
    v(0,0,0,0,0, 0,0,1,4'hC, 1,1,1,0, 2,2);
    v(0,0,0,0,0, 0,0,1,4'hC, 1,1,1,0, 2,2);
    v(0,0,0,0,0, 0,0,1,4'hC, 0,1,1,1, 3,3);
    v(0,0,0,0,0, 0,0,0,4'h0, 1,1,1,0, 3,3);
    v(0,0,0,0,0, 0,0,1,4'hC, 1,1,1,0, 3,3);
    v(0,0,0,0,0, 0,0,1,4'hC, 1,1,1,0, 3,3);
    v(0,0,0,0,0, 0,0,1,4'hC, 0,1,1,1, 4,3);
    v(0,0,0,0,0, 0,0,0,4'h0, 1,1,1,0, 4,3);
    v(0,0,0,0,0, 0,1,0,4'h0, 0,0,1,0, 4,3);
    // stop priority, restart, config lockout in SCAN
    v(0,1,4'hC,4'hF,2, 1,0,0,4'h0, 1,1,1,0, 4,3);
    v(0,0,0,0,0, 0,0,1,4'h0, 1,1,0,0, 4,3);
    v(0,0,0,0,0, 0,0,1,4'hC, 1,1,1,0, 4,3);
    v(0,0,0,0,0, 0,1,1,4'hC, 0,0,1,0, 4,3);
    v(0,0,0,0,0, 1,0,0,4'h0, 1,1,1,0, 4,3);
    v(0,0,0,0,0, 0,0,1,4'hC, 1,1,1,0, 4,3);
    v(0,0,0,0,0, 0,0,1,4'hC, 0,1,1,1, 5,3);
    v(0,0,0,0,0, 0,0,0,4'h0, 1,1,1,0, 5,3);
    v(0,1,4'h0,4'hF,1, 1,0,0,4'h0, 1,1,1,0, 5,3);
    v(0,0,0,0,0, 0,0,1,4'hC, 1,1,1,0, 5,3);
    v(0,0,0,0,0, 0,0,1,4'hC, 0,1,1,1, 6,3);
    v(0,0,0,0,0, 0,0,0,4'h0, 1,1,1,0, 6,3);
    v(0,0,0,0,0, 0,0,1,4'h0, 1,1,0,0, 6,3);
    v(0,0,0,0,0, 0,1,0,4'h0, 0,0,0,0, 6,3);
    // cfg_run = 0 behaves as 1; write in SCAN ignored
    v(0,1,4'hC,4'hF,0, 1,0,0,4'h0, 1,1,0,0, 6,3);
    v(0,0,0,0,0, 0,0,1,4'hC, 0,1,1,1, 7,3);
    v(0,0,0,0,0, 0,0,0,4'h0, 1,1,1,0, 7,3);
    v(0,1,4'h0,4'hF,0, 0,0,0,4'h0, 1,1,1,0, 7,3);
    v(0,0,0,0,0, 0,0,1,4'hC, 0,1,1,1, 8,3);
    v(0,0,0,0,0, 0,0,0,4'h0, 1,1,1,0, 8,3);
    v(0,0,0,0,0, 0,1,0,4'h0, 0,0,1,0, 8,3);
    v(0,0,0,0,0, 0,1,0,4'h0, 0,0,1,0, 8,3);
    // stop while in HIT
    v(0,1,4'hC,4'hF,1, 1,0,0,4'h0, 1,1,1,0, 8,3);
    v(0,0,0,0,0, 0,0,1,4'hC, 0,1,1,1, 9,3);
    v(0,0,0,0,0, 0,1,0,4'h0, 0,0,1,0, 9,3);
    // reset mid-scan at run_cnt 2 of 3, overriding start and cfg_we
    v(0,1,4'hC,4'hF,3, 1,0,0,4'h0, 1,1,1,0, 9,3);
    v(0,0,0,0,0, 0,0,1,4'hC, 1,1,1,0, 9,3);
    v(0,0,0,0,0, 0,0,1,4'hC, 1,1,1,0, 9,3);
    v(1,1,4'h5,4'hF,3, 1,0,1,4'hC, 0,0,0,0, 0,0);
    v(0,0,0,0,0, 1,0,1,4'h5, 1,1,0,0, 0,0);
    v(0,0,0,0,0, 0,0,1,4'h5, 0,1,1,1, 1,1);
    v(0,0,0,0,0, 0,0,0,4'h0, 1,1,1,0, 1,1);
    v(0,0,0,0,0, 0,1,0,4'h0, 0,0,1,0, 1,1);

    rst = 1'b1;
    tick("reset0");
    tick("reset1");
    chk("reset_outputs", {in_ready, busy, match_last, hit, hit_count}, 12'h000);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r; cfg_we = tbl[i].we; cfg_pattern = tbl[i].pat;
      cfg_mask = tbl[i].msk; cfg_run = tbl[i].run; start = tbl[i].st;
      stop = tbl[i].sp; in_valid = tbl[i].vl; in_data = tbl[i].d;
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_flags", i), {in_ready, busy, match_last, hit},
          {tbl[i].er, tbl[i].eb, tbl[i].eml, tbl[i].eh});
      chk($sformatf("vec%0d_count", i), {hit_count, 6'd0, hit_count_s},
          {8'(tbl[i].ec), 6'd0, 2'(tbl[i].ecs)});
    end

    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 1499) == 0);
      cfg_we      = ($urandom_range(0, 7) == 0);
      cfg_pattern = 4'($urandom);
      cfg_mask    = 4'($urandom);
      cfg_run     = 4'($urandom_range(0, 4));
      start       = ($urandom_range(0, 5) == 0);
      stop        = ($urandom_range(0, 24) == 0);
      in_valid    = ($urandom_range(0, 1) == 1);
      in_data     = ($urandom_range(0, 2) != 0) ? m_pat : 4'($urandom);
      tick("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
